// File: rtl/minhash_collector_if.sv
// ============================================================================
// Module      : minhash_collector_if
// Description : Hash-stream input, signature-stream output and document
//               control signals of the MinHash collector. The slave modport
//               is the collector's view; the master modport is the
//               surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface minhash_collector_if #(
  parameter int NUM_HASH = 4,
  parameter int IDX_W    = $clog2(NUM_HASH)
);
  // Document control
  logic             start;
  logic             busy;
  logic             done;
  logic             dropped;
  // Hash stream from the murmur units
  logic [31:0]      hash_val;
  logic             hash_valid;
  logic             last_shingle;
  logic [IDX_W-1:0] seed_idx;
  // Signature stream toward LSH banding
  logic [31:0]      sig_out;
  logic [IDX_W-1:0] sig_idx;
  logic             sig_valid;
  logic             sig_ready;

  modport master (
    output start, hash_val, hash_valid, last_shingle, sig_ready,
    input  busy, done, dropped, seed_idx, sig_out, sig_idx, sig_valid
  );

  modport slave (
    input  start, hash_val, hash_valid, last_shingle, sig_ready,
    output busy, done, dropped, seed_idx, sig_out, sig_idx, sig_valid
  );
endinterface

`default_nettype wire

// File: rtl/minhash_collector.sv
// ============================================================================
// Module      : minhash_collector
// Description : Keeps the running unsigned minimum of every seed's hash over
//               all shingles of a document, drives the seed index back to the
//               hash stage, then streams the finished MinHash signature out
//               one word per accepted beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module minhash_collector #(
  parameter int NUM_HASH = 4,
  parameter int IDX_W    = $clog2(NUM_HASH)
) (
  input  logic                  clk,
  input  logic                  reset,
  minhash_collector_if.slave    bus
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_HASH - 1);
  localparam logic [31:0]      c_MIN_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_min [NUM_HASH];
  logic [IDX_W-1:0] r_seed_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [31:0]      r_sig_out;
  logic             r_sig_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_dropped;

  logic             w_hash_lower;
  logic [IDX_W-1:0] w_rd_next;
  logic             w_last_beat;

  // Unsigned compare: an equal hash leaves the stored minimum untouched.
  assign w_hash_lower = bus.hash_val < r_min[r_seed_idx];
  // Index wraps naturally because NUM_HASH is a power of two.
  assign w_rd_next    = r_rd_idx + 1'b1;
  assign w_last_beat  = (r_seed_idx == c_LAST_IDX) && bus.last_shingle;

  // Collector state machine: min tracking, seed sequencing and signature drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_seed_idx  <= '0;
      r_rd_idx    <= '0;
      r_sig_out   <= '0;
      r_sig_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dropped   <= 1'b0;
      for (int i = 0; i < NUM_HASH; i++) begin
        r_min[i] <= c_MIN_INIT;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // A start in the same cycle as a stray hash wins: dropped clears.
            for (int i = 0; i < NUM_HASH; i++) begin
              r_min[i] <= c_MIN_INIT;
            end
            r_seed_idx <= '0;
            r_dropped  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_COLLECT;
          end else if (bus.hash_valid) begin
            r_dropped <= 1'b1;
          end
        end

        S_COLLECT: begin
          if (bus.hash_valid) begin
            if (w_hash_lower) begin
              r_min[r_seed_idx] <= bus.hash_val;
            end
            r_seed_idx <= r_seed_idx + 1'b1;
            if (w_last_beat) begin
              // The final beat only touches the last seed, so min[0] is
              // already final and can be presented as the first word.
              r_seed_idx  <= '0;
              r_rd_idx    <= '0;
              r_sig_out   <= r_min[0];
              r_sig_valid <= 1'b1;
              r_state     <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (bus.hash_valid) begin
            r_dropped <= 1'b1;
          end
          if (bus.sig_ready) begin
            r_rd_idx <= w_rd_next;
            if (r_rd_idx == c_LAST_IDX) begin
              r_sig_out   <= '0;
              r_sig_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_sig_out <= r_min[w_rd_next];
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.seed_idx  = r_seed_idx;
  assign bus.sig_out   = r_sig_out;
  assign bus.sig_idx   = r_rd_idx;
  assign bus.sig_valid = r_sig_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dropped   = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_minhash_collector.sv
// ============================================================================
// Module      : tb_minhash_collector
// Description : Self-checking bench for minhash_collector. Expected
//               signatures are the per-seed unsigned minimum of every hash
//               sent for the document, recomputed from the stored hash list.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minhash_collector;

  localparam int NH = 4;
  localparam int IW = $clog2(NH);

  logic clk;
  logic reset;

  minhash_collector_if #(.NUM_HASH(NH), .IDX_W(IW)) bus ();

  minhash_collector #(.NUM_HASH(NH), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Every hash accepted for the current document, in arrival order.
  logic [31:0] q_hash [$];
  int          beat_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Seed s receives beats s, s+NH, s+2*NH, ...; expected word is their minimum.
  function automatic logic [31:0] exp_min(input int s);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    for (int i = s; i < q_hash.size(); i += NH) begin
      if (q_hash[i] < m) m = q_hash[i];
    end
    return m;
  endfunction

  task automatic start_doc(input bit with_hash);
    q_hash.delete();
    beat_cnt       = 0;
    bus.start      = 1'b1;
    bus.hash_valid = with_hash;
    bus.hash_val   = $urandom;
    tick();
    bus.start      = 1'b0;
    bus.hash_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.dropped !== 1'b0 || bus.seed_idx !== '0 || bus.sig_valid !== 1'b0)
      begin
        n_fail++;
        $display("FAIL start_doc: busy=%b dropped=%b seed_idx=%0d sig_valid=%b expected 1 0 0 0",
                 bus.busy, bus.dropped, bus.seed_idx, bus.sig_valid);
      end
  endtask

  task automatic send_beat(input logic [31:0] h, input logic last, input bit is_final);
    n_checks++;
    if (bus.seed_idx !== IW'(beat_cnt % NH)) begin
      n_fail++;
      $display("FAIL seed_idx: got %0d expected %0d", bus.seed_idx, beat_cnt % NH);
    end
    bus.hash_val     = h;
    bus.hash_valid   = 1'b1;
    bus.last_shingle = last;
    q_hash.push_back(h);
    tick();
    bus.hash_valid   = 1'b0;
    bus.last_shingle = 1'b0;
    bus.hash_val     = $urandom;
    beat_cnt++;
    n_checks++;
    if (bus.sig_valid !== is_final) begin
      n_fail++;
      $display("FAIL sig_valid_after_beat: got %b expected %b (beat %0d)", bus.sig_valid, is_final, beat_cnt);
    end
  endtask

  // Random hashes with occasional repeats (equal compare) and all-ones values.
  // last_shingle is asserted at random on non-final seeds to show it is ignored.
  task automatic send_beats(input int nbeats, input int max_gap, input bit end_doc);
    logic [31:0] h;
    bit          fin;
    for (int b = 0; b < nbeats; b++) begin
      case ($urandom_range(0, 5))
        0:       h = (q_hash.size() >= NH) ? q_hash[q_hash.size() - NH] : $urandom;
        1:       h = 32'hFFFF_FFFF;
        default: h = $urandom;
      endcase
      fin = end_doc && (b == nbeats - 1);
      repeat ($urandom_range(0, max_gap)) tick();
      if (fin)
        send_beat(h, 1'b1, 1'b1);
      else if ((beat_cnt % NH) != NH - 1)
        send_beat(h, 1'($urandom_range(0, 1)), 1'b0);
      else
        send_beat(h, 1'b0, 1'b0);
    end
  endtask

  task automatic drain_check(input int stall_word, input int stall_cycles, input bit rand_ready);
    int   k;
    int   cyc;
    int   st;
    logic rdy;
    k = 0; cyc = 0; st = 0;
    while (k < NH && cyc < 300) begin
      n_checks++;
      if (bus.sig_valid !== 1'b1 || bus.sig_idx !== IW'(k) || bus.sig_out !== exp_min(k)) begin
        n_fail++;
        $display("FAIL sig_word: valid=%b idx=%0d out=%h expected valid=1 idx=%0d out=%h",
                 bus.sig_valid, bus.sig_idx, bus.sig_out, k, exp_min(k));
      end
      if (k == stall_word && st < stall_cycles) begin
        rdy = 1'b0;
        st++;
      end else if (rand_ready) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      bus.sig_ready = rdy;
      tick();
      cyc++;
      if (rdy) k++;
    end
    bus.sig_ready = 1'b0;
    n_checks++;
    if (k != NH) begin
      n_fail++;
      $display("FAIL drain_timeout: accepted %0d words expected %0d", k, NH);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.sig_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b sig_valid=%b expected 1 0 0",
               bus.done, bus.busy, bus.sig_valid);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dropped !== 1'b0 || bus.sig_valid !== 1'b0 ||
        bus.sig_out !== 32'h0 || bus.sig_idx !== '0 || bus.seed_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b dropped=%b valid=%b out=%h idx=%0d seed=%0d expected all 0",
               bus.busy, bus.done, bus.dropped, bus.sig_valid, bus.sig_out, bus.sig_idx, bus.seed_idx);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.sig_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b sig_valid=%b expected 0 0", bus.busy, bus.sig_valid);
    end
  endtask

  task automatic test_random_docs();
    start_doc(1'b0);
    send_beats(4 * NH, 0, 1'b1);
    drain_check(-1, 0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      start_doc(1'b0);
      send_beats(NH * $urandom_range(1, 6), 3, 1'b1);
      drain_check(-1, 0, 1'b1);
    end
  endtask

  task automatic test_single_shingle();
    start_doc(1'b0);
    send_beat(32'h8000_0000, 1'b0, 1'b0);
    send_beat(32'h0000_0001, 1'b0, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b1, 1'b1);
    drain_check(-1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    start_doc(1'b0);
    send_beats(3 * NH, 2, 1'b1);
    drain_check(2, 3, 1'b0);
  endtask

  task automatic stray_hash();
    bus.hash_valid = 1'b1;
    bus.hash_val   = 32'h0;
    tick();
    bus.hash_valid = 1'b0;
    n_checks++;
    if (bus.dropped !== 1'b1) begin
      n_fail++;
      $display("FAIL dropped_set: got %b expected 1", bus.dropped);
    end
  endtask

  task automatic test_dropped();
    // Stray hash while the signature waits in DRAIN.
    start_doc(1'b0);
    send_beats(2 * NH, 0, 1'b1);
    stray_hash();
    drain_check(-1, 0, 1'b0);
    n_checks++;
    if (bus.dropped !== 1'b1) begin
      n_fail++;
      $display("FAIL dropped_sticky: got %b expected 1", bus.dropped);
    end
    // Stray hash in IDLE starting from a clean flag.
    start_doc(1'b0);
    send_beats(NH, 0, 1'b1);
    drain_check(-1, 0, 1'b0);
    stray_hash();
    // Start with a simultaneous hash: start wins, hash is discarded.
    start_doc(1'b1);
    send_beats(2 * NH, 1, 1'b1);
    drain_check(-1, 0, 1'b0);
  endtask

  task automatic test_start_in_collect();
    start_doc(1'b0);
    for (int b = 0; b < NH + 2; b++) send_beat(32'h100 + b, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.seed_idx !== IW'(2) || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_collect: seed_idx=%0d busy=%b expected 2 1", bus.seed_idx, bus.busy);
    end
    for (int b = 0; b < NH - 3; b++) send_beat(32'hF000_0000 + b, 1'b0, 1'b0);
    send_beat(32'hF000_00FF, 1'b1, 1'b1);
    drain_check(-1, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    start_doc(1'b0);
    send_beats(NH + 2, 0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.seed_idx !== '0 || bus.sig_valid !== 1'b0 || bus.dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b seed_idx=%0d sig_valid=%b dropped=%b expected 0 0 0 0",
               bus.busy, bus.seed_idx, bus.sig_valid, bus.dropped);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    start_doc(1'b0);
    send_beats(3 * NH, 2, 1'b1);
    drain_check(-1, 0, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.hash_val     = 32'h0;
    bus.hash_valid   = 1'b0;
    bus.last_shingle = 1'b0;
    bus.sig_ready    = 1'b0;
    test_reset();
    test_random_docs();
    test_single_shingle();
    test_backpressure();
    test_dropped();
    test_start_in_collect();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/minhash_collector.md
# minhash_collector

Consumer of the 32-bit hash stream produced by the murmur hash units: for every shingle of a document it receives one hash per seed, keeps the running unsigned minimum per seed, and after the last shingle streams out the finished MinHash signature word by word. It sits between the hash stage and the LSH banding stage. It also drives the seed index that the hash stage uses, so both ends agree on which minimum each hash belongs to.

## Interface
Parameters:
- NUM_HASH, default 4: signature length (seeds per shingle). Must be a power of two, ≥ 2.
- IDX_W, default $clog2(NUM_HASH): width of the index ports.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new document. Sampled only in IDLE.
- hash_val  in  32  hash result from the hash unit.
- hash_valid  in  1  hash_val is valid this cycle (the hash unit's completion flag).
- last_shingle  in  1  qualifies the current shingle as the document's last. Sampled only on the beat where seed_idx == NUM_HASH-1.
- seed_idx  out  IDX_W  seed the hash stage must use for the next hash.
- sig_out  out  32  signature word.
- sig_idx  out  IDX_W  index of sig_out within the signature.
- sig_valid  out  1  sig_out/sig_idx are valid.
- sig_ready  in  1  downstream accepts the word when sig_valid && sig_ready.
- busy  out  1  high in COLLECT and DRAIN.
- done  out  1  one-cycle pulse after the last signature word is accepted.
- dropped  out  1  sticky; a hash_valid arrived outside COLLECT. Cleared by an accepted start.

## Operation
- State register: IDLE, COLLECT, DRAIN.
- Storage: min[0..NUM_HASH-1] (32 bits each), seed_idx counter, rd_idx counter.
- IDLE:
  - On start: all min ← 32'hFFFFFFFF, seed_idx ← 0, dropped ← 0, go to COLLECT.
- COLLECT, on hash_valid:
  - min[seed_idx] ← (hash_val < min[seed_idx]) ? hash_val : min[seed_idx], using an unsigned compare. An equal value leaves the entry unchanged.
  - seed_idx increments and wraps from NUM_HASH-1 to 0.
  - If seed_idx == NUM_HASH-1 and last_shingle = 1: update the min, go to DRAIN, rd_idx ← 0, seed_idx ← 0.
  - Without hash_valid, nothing changes. Gaps of any length between beats are legal.
- DRAIN:
  - sig_valid = 1, sig_out = min[rd_idx], sig_idx = rd_idx.
  - On sig_ready, rd_idx increments.
  - On acceptance of the word at rd_idx == NUM_HASH-1: go to IDLE and pulse done.
- start is ignored in COLLECT and DRAIN and has no effect on dropped.
- hash_valid in IDLE or DRAIN:
  - The beat is discarded and dropped ← 1.
  - In IDLE, a start in the same cycle wins: dropped is cleared and the hash is discarded.
- last_shingle on a beat with seed_idx ≠ NUM_HASH-1 is ignored.
- Asynchronous reset mid-operation: every register returns to its reset value at once and any partial signature is lost.

## Timing
- Reset values:
  - state = IDLE; seed_idx, rd_idx, sig_out and sig_idx = 0.
  - sig_valid, busy, done and dropped = 0.
  - all min = 32'hFFFFFFFF.
- start to busy: 1 cycle (the state is registered).
- Min update: visible the cycle after the hash_valid beat.
- seed_idx: advances the cycle after each accepted beat, so the hash unit sees the new index before its next computation.
- First sig_valid: asserted the cycle after the final beat of the last shingle.
- sig_out/sig_idx: held stable while sig_valid && !sig_ready.
- Drain throughput: with sig_ready tied high, one word per cycle. NUM_HASH words take NUM_HASH cycles.
- done: asserted in the cycle after the last word is accepted, together with busy = 0.
- A new start is accepted in the cycle done is high.

## Test plan
- Reset release, then start. After 4 shingles of hash_val {A,B,C,D} (with NUM_HASH = 4), sig_out over sig_idx 0..3 equals the per-seed unsigned minimum, and done pulses once.
- Single shingle: hashes 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF with last_shingle on the 4th beat:
  - the signature is 80000000, 00000001, FFFFFFFF, 7FFFFFFF (the unsigned compare is kept and FFFFFFFF survives);
  - first sig_valid appears exactly 1 cycle after the 4th beat.
- Backpressure: sig_ready low for 3 cycles on word 2. sig_out and sig_idx are unchanged throughout, and rd_idx does not skip.
- hash_valid during DRAIN, and again in IDLE: dropped rises and the signature is unaffected. The next start clears dropped.
- start pulsed during COLLECT: ignored, seed_idx continues without restarting, and the mins are not re-initialised.
- Reset asserted in the middle of shingle 2: outputs return to their reset values within the same cycle, with no clock edge needed. A following document gives a correct signature.
